// File: rtl/dma_arb_pkg.sv
// Shared definitions for the DMA channel-priority arbiter.
// Holds the arbitration state encoding and the default channel count.
package dma_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANTED = 2'd1,
      ACTIVE  = 2'd2
   } arb_state_e;

   localparam int unsigned DEFAULT_NUM_CH = 4;

endpackage

// File: rtl/dma_rr_find_first.sv
// Combinational find-first-set over a request vector.
// The search starts at ptr_i and wraps modulo NUM_CH.
module dma_rr_find_first
   import dma_arb_pkg::*;
#(
   parameter  int unsigned NUM_CH = DEFAULT_NUM_CH,
   localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic [CH_W-1:0]   idx_o,
   output logic              found_o
);

   logic            done;
   logic [CH_W-1:0] cand;

   always_comb begin
      idx_o = '0;
      done  = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cand = CH_W'((32'(ptr_i) + i) % NUM_CH);
         if (!done && req_i[cand]) begin
            idx_o = cand;
            done  = 1'b1;
         end
      end
   end

   assign found_o = |req_i;

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel-priority arbiter: samples DREQ, merges software requests and
// masks, picks a winner (fixed or rotating) and drives DACK through service.
module dma_priority_arbiter
   import dma_arb_pkg::*;
#(
   parameter  int unsigned NUM_CH = DEFAULT_NUM_CH,
   localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [NUM_CH-1:0] DREQ,
   input  logic [NUM_CH-1:0] RequestReg,
   input  logic [NUM_CH-1:0] MaskedReg,
   input  logic              RotatingPriority,
   input  logic              DREQ_Sense,
   input  logic              DACK_Sense,
   input  logic              MemToMem,
   input  logic              PriorityGen,
   input  logic              ldAck,
   input  logic              ServiceDone,
   output logic              DMA_Req,
   output logic [CH_W-1:0]   ActiveChannel,
   output logic              GrantValid,
   output logic [NUM_CH-1:0] DACK,
   output logic [NUM_CH-1:0] ReqStatus
);

   arb_state_e        state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [NUM_CH-1:0] dreq_q;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] dack_raw;
   logic [CH_W-1:0]   ptr_eff;
   logic [CH_W-1:0]   win_idx;
   logic              win_found;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         dreq_q <= '0;
      end else begin
         dreq_q <= DREQ_Sense ? DREQ : ~DREQ;
      end
   end

   // Memory-to-memory transfers are driven only by the software request of ch0.
   always_comb begin
      eligible = '0;
      if (MemToMem) begin
         eligible[0] = RequestReg[0];
      end else begin
         eligible = (dreq_q & ~MaskedReg) | RequestReg;
      end
   end

   assign DMA_Req   = |eligible;
   assign ReqStatus = dreq_q | RequestReg;
   assign ptr_eff   = RotatingPriority ? ptr_q : '0;

   dma_rr_find_first #(
      .NUM_CH(NUM_CH)
   ) u_find (
      .req_i   (eligible),
      .ptr_i   (ptr_eff),
      .idx_o   (win_idx),
      .found_o (win_found)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         ch_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      ptr_d   = RotatingPriority ? ptr_q : '0;
      unique case (state_q)
         IDLE: begin
            if (PriorityGen && win_found) begin
               ch_d    = win_idx;
               state_d = GRANTED;
            end
         end
         GRANTED: begin
            // Withdrawal or early completion takes precedence over ldAck.
            if (!eligible[ch_q] || ServiceDone) begin
               state_d = IDLE;
            end else if (ldAck) begin
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (ServiceDone) begin
               state_d = IDLE;
               if (RotatingPriority) begin
                  ptr_d = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dack_raw = '0;
      if (state_q == ACTIVE) begin
         dack_raw[ch_q] = 1'b1;
      end
   end

   assign DACK          = dack_raw ^ {NUM_CH{~DACK_Sense}};
   assign GrantValid    = (state_q != IDLE);
   assign ActiveChannel = ch_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter (NUM_CH=4): directed scenarios
// plus randomized traffic checked against a behavioural model.
module tb_dma_priority_arbiter;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [3:0] DREQ, RequestReg, MaskedReg;
   logic       RotatingPriority, DREQ_Sense, DACK_Sense, MemToMem;
   logic       PriorityGen, ldAck, ServiceDone;
   logic       DMA_Req, GrantValid;
   logic [1:0] ActiveChannel;
   logic [3:0] DACK, ReqStatus;

   int total = 0;
   int bad   = 0;

   // Model: phase 0 = no grant, 1 = winner chosen, 2 = being serviced.
   logic [3:0] m_dreq;
   int         m_phase, m_ptr, m_ch;

   dma_priority_arbiter #(.NUM_CH(4)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .RequestReg(RequestReg),
      .MaskedReg(MaskedReg), .RotatingPriority(RotatingPriority),
      .DREQ_Sense(DREQ_Sense), .DACK_Sense(DACK_Sense), .MemToMem(MemToMem),
      .PriorityGen(PriorityGen), .ldAck(ldAck), .ServiceDone(ServiceDone),
      .DMA_Req(DMA_Req), .ActiveChannel(ActiveChannel), .GrantValid(GrantValid),
      .DACK(DACK), .ReqStatus(ReqStatus)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [3:0] m_elig();
      if (MemToMem) return {3'b000, RequestReg[0]};
      return (m_dreq & ~MaskedReg) | RequestReg;
   endfunction

   function automatic logic [3:0] exp_dack();
      logic [3:0] d;
      d = (m_phase == 2) ? (4'b0001 << m_ch) : 4'b0000;
      return DACK_Sense ? d : ~d;
   endfunction

   task automatic model_reset();
      m_dreq  = 4'b0000;
      m_phase = 0;
      m_ptr   = 0;
      m_ch    = 0;
   endtask

   task automatic step();
      logic [3:0] el;
      int         start, n_phase, n_ptr, n_ch;
      el      = m_elig();
      start   = RotatingPriority ? m_ptr : 0;
      n_phase = m_phase;
      n_ch    = m_ch;
      n_ptr   = RotatingPriority ? m_ptr : 0;
      if (m_phase == 0) begin
         if (PriorityGen && el != 4'b0000) begin
            for (int k = 3; k >= 0; k--)
               if (el[(start + k) % 4]) n_ch = (start + k) % 4;
            n_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (!el[m_ch] || ServiceDone) n_phase = 0;
         else if (ldAck) n_phase = 2;
      end else begin
         if (ServiceDone) begin
            n_phase = 0;
            if (RotatingPriority) n_ptr = (m_ch + 1) % 4;
         end
      end
      @(posedge CLK);
      #1;
      m_phase = n_phase;
      m_ch    = n_ch;
      m_ptr   = n_ptr;
      m_dreq  = DREQ_Sense ? DREQ : ~DREQ;
   endtask

   task automatic defaults();
      DREQ = 4'b0000; RequestReg = 4'b0000; MaskedReg = 4'b0000;
      RotatingPriority = 1'b0; DREQ_Sense = 1'b1; DACK_Sense = 1'b1;
      MemToMem = 1'b0; PriorityGen = 1'b0; ldAck = 1'b0; ServiceDone = 1'b0;
   endtask

   task automatic do_reset();
      defaults();
      @(negedge CLK);
      RESET_N = 1'b0;
      model_reset();
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
   endtask

   task automatic pulse_pg();
      PriorityGen = 1'b1; step(); PriorityGen = 1'b0;
   endtask

   task automatic pulse_ack();
      ldAck = 1'b1; step(); ldAck = 1'b0;
   endtask

   task automatic pulse_done();
      ServiceDone = 1'b1; step(); ServiceDone = 1'b0;
   endtask

   task automatic test_reset();
      defaults();
      DREQ = 4'b1111; RequestReg = 4'b0100; DACK_Sense = 1'b0;
      @(negedge CLK);
      RESET_N = 1'b0;
      model_reset();
      #3;
      total++; if (GrantValid !== 1'b0) begin bad++; $display("FAIL reset_gv got=%b exp=0", GrantValid); end
      total++; if (ActiveChannel !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", ActiveChannel); end
      total++; if (DACK !== 4'b1111) begin bad++; $display("FAIL reset_dack got=%b exp=1111", DACK); end
      total++; if (ReqStatus !== 4'b0100) begin bad++; $display("FAIL reset_status got=%b exp=0100", ReqStatus); end
      total++; if (DMA_Req !== 1'b1) begin bad++; $display("FAIL reset_dmareq got=%b exp=1", DMA_Req); end
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
   endtask

   task automatic test_fixed_dack();
      do_reset();
      DREQ = 4'b1010;
      total++; if (DMA_Req !== 1'b0) begin bad++; $display("FAIL fixed_latency got=%b exp=0", DMA_Req); end
      step();
      total++; if (DMA_Req !== 1'b1) begin bad++; $display("FAIL fixed_dmareq got=%b exp=1", DMA_Req); end
      pulse_pg();
      total++; if (ActiveChannel !== 2'd1) begin bad++; $display("FAIL fixed_ch got=%0d exp=1", ActiveChannel); end
      total++; if (GrantValid !== 1'b1) begin bad++; $display("FAIL fixed_gv got=%b exp=1", GrantValid); end
      total++; if (DACK !== 4'b0000) begin bad++; $display("FAIL fixed_dack_pre got=%b exp=0000", DACK); end
      pulse_ack();
      total++; if (DACK !== 4'b0010) begin bad++; $display("FAIL fixed_dack_hi got=%b exp=0010", DACK); end
      DACK_Sense = 1'b0;
      #1;
      total++; if (DACK !== 4'b1101) begin bad++; $display("FAIL fixed_dack_lo got=%b exp=1101", DACK); end
      DACK_Sense = 1'b1;
      pulse_done();
      total++; if (GrantValid !== 1'b0) begin bad++; $display("FAIL fixed_gv_done got=%b exp=0", GrantValid); end
      total++; if (DACK !== 4'b0000) begin bad++; $display("FAIL fixed_dack_done got=%b exp=0000", DACK); end
   endtask

   task automatic test_rotating();
      do_reset();
      RotatingPriority = 1'b1;
      DREQ = 4'b1111;
      step();
      for (int r = 0; r < 5; r++) begin
         pulse_pg();
         total++; if (ActiveChannel !== 2'(r % 4)) begin bad++; $display("FAIL rot_ch round=%0d got=%0d exp=%0d", r, ActiveChannel, r % 4); end
         pulse_ack();
         total++; if (DACK !== (4'b0001 << (r % 4))) begin bad++; $display("FAIL rot_dack round=%0d got=%b exp=%b", r, DACK, 4'b0001 << (r % 4)); end
         pulse_done();
      end
   endtask

   task automatic test_mask();
      do_reset();
      MaskedReg = 4'b0001; DREQ = 4'b0001;
      step();
      total++; if (DMA_Req !== 1'b0) begin bad++; $display("FAIL mask_off got=%b exp=0", DMA_Req); end
      total++; if (ReqStatus !== 4'b0001) begin bad++; $display("FAIL mask_status got=%b exp=0001", ReqStatus); end
      RequestReg = 4'b0001;
      #1;
      total++; if (DMA_Req !== 1'b1) begin bad++; $display("FAIL mask_sw got=%b exp=1", DMA_Req); end
      pulse_pg();
      total++; if (ActiveChannel !== 2'd0 || GrantValid !== 1'b1) begin bad++; $display("FAIL mask_grant got=%0d/%b exp=0/1", ActiveChannel, GrantValid); end
      pulse_done();
   endtask

   task automatic test_memtomem();
      do_reset();
      MemToMem = 1'b1; DREQ = 4'b0110; RequestReg = 4'b0001;
      step();
      pulse_pg();
      total++; if (ActiveChannel !== 2'd0 || GrantValid !== 1'b1) begin bad++; $display("FAIL m2m_grant got=%0d/%b exp=0/1", ActiveChannel, GrantValid); end
      pulse_done();
      RequestReg = 4'b0000;
      #1;
      total++; if (DMA_Req !== 1'b0) begin bad++; $display("FAIL m2m_dmareq got=%b exp=0", DMA_Req); end
      pulse_pg();
      total++; if (GrantValid !== 1'b0) begin bad++; $display("FAIL m2m_nogrant got=%b exp=0", GrantValid); end
   endtask

   task automatic test_withdraw();
      do_reset();
      RotatingPriority = 1'b1;
      DREQ = 4'b0010;
      step();
      pulse_pg(); pulse_ack(); pulse_done();
      DREQ = 4'b0100;
      step();
      pulse_pg();
      total++; if (ActiveChannel !== 2'd2 || GrantValid !== 1'b1) begin bad++; $display("FAIL wd_grant got=%0d/%b exp=2/1", ActiveChannel, GrantValid); end
      DREQ = 4'b0000;
      step();
      total++; if (DACK !== 4'b0000) begin bad++; $display("FAIL wd_dack_mid got=%b exp=0000", DACK); end
      ldAck = 1'b1;
      step();
      ldAck = 1'b0;
      total++; if (GrantValid !== 1'b0) begin bad++; $display("FAIL wd_gv got=%b exp=0", GrantValid); end
      total++; if (DACK !== 4'b0000) begin bad++; $display("FAIL wd_dack got=%b exp=0000", DACK); end
      DREQ = 4'b1111;
      step();
      pulse_pg();
      total++; if (ActiveChannel !== 2'd2) begin bad++; $display("FAIL wd_ptr got=%0d exp=2", ActiveChannel); end
      pulse_done();
   endtask

   task automatic test_reset_mid();
      do_reset();
      RotatingPriority = 1'b1;
      DREQ = 4'b0010;
      step();
      pulse_pg(); pulse_ack(); pulse_done();
      DREQ = 4'b1000;
      step();
      pulse_pg(); pulse_ack();
      total++; if (DACK !== 4'b1000) begin bad++; $display("FAIL rst_mid_active got=%b exp=1000", DACK); end
      #2;
      RESET_N = 1'b0;
      model_reset();
      #1;
      total++; if (DACK !== 4'b0000) begin bad++; $display("FAIL rst_mid_dack got=%b exp=0000", DACK); end
      total++; if (GrantValid !== 1'b0) begin bad++; $display("FAIL rst_mid_gv got=%b exp=0", GrantValid); end
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      DREQ = 4'b1111;
      step();
      pulse_pg();
      total++; if (ActiveChannel !== 2'd0) begin bad++; $display("FAIL rst_mid_ptr got=%0d exp=0", ActiveChannel); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         DREQ             = 4'($urandom);
         RequestReg       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         MaskedReg        = 4'($urandom);
         if ($urandom_range(0, 15) == 0) RotatingPriority = ~RotatingPriority;
         if ($urandom_range(0, 31) == 0) DREQ_Sense = ~DREQ_Sense;
         if ($urandom_range(0, 15) == 0) DACK_Sense = ~DACK_Sense;
         MemToMem         = ($urandom_range(0, 9) == 0);
         PriorityGen      = ($urandom_range(0, 2) == 0);
         ldAck            = ($urandom_range(0, 2) == 0);
         ServiceDone      = ($urandom_range(0, 4) == 0);
         #1;
         total++; if (DMA_Req !== (m_elig() != 4'b0000)) begin bad++; $display("FAIL rnd_dmareq i=%0d got=%b exp=%b", i, DMA_Req, m_elig() != 4'b0000); end
         total++; if (GrantValid !== (m_phase != 0)) begin bad++; $display("FAIL rnd_gv i=%0d got=%b exp=%b", i, GrantValid, m_phase != 0); end
         total++; if (ActiveChannel !== 2'(m_ch)) begin bad++; $display("FAIL rnd_ch i=%0d got=%0d exp=%0d", i, ActiveChannel, m_ch); end
         total++; if (DACK !== exp_dack()) begin bad++; $display("FAIL rnd_dack i=%0d got=%b exp=%b", i, DACK, exp_dack()); end
         total++; if (ReqStatus !== (m_dreq | RequestReg)) begin bad++; $display("FAIL rnd_status i=%0d got=%b exp=%b", i, ReqStatus, m_dreq | RequestReg); end
         step();
      end
      defaults();
   endtask

   initial begin
      RESET_N = 1'b1;
      defaults();
      model_reset();
      test_reset();
      test_fixed_dack();
      test_rotating();
      test_mask();
      test_memtomem();
      test_withdraw();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
